reply_frame_gen: RTL
====================

Name: reply_frame_gen

Overview:
- Bit-serial frame generator directly upstream of the Miller/FM0 encoders in the tag backscatter path.
- After a start request it waits out the encoder's pilot/preamble window, then emits one reply bit per clk_frm cycle on send_data.
- Frame order: optional header bit, payload words fetched from the memory interface, optional handle, CRC-16, trailing dummy-1.
- Then asserts fg_complete and holds it until the next reset.

Parameters:
- LEAD_SHORT, 10, lead cycles from frame start to first bit when trext=0.
- LEAD_LONG, 34, lead cycles when trext=1.
- WCNT_W, 8, width of the payload word count.

Ports:
- clk_frm  input  1  bit-rate clock, same frequency and phase as the encoder clock.
- rst_for_new_package  input  1  asynchronous, active-high reset; asserted between packages.
- st_enc  input  1  level start; a 0->1 transition seen while IDLE starts a frame.
- trext  input  1  selects LEAD_LONG (1) or LEAD_SHORT (0); sampled at start.
- header_en  input  1  prepend a single '0' header bit; sampled at start.
- crc_en  input  1  append CRC-16; sampled at start.
- word_cnt  input  WCNT_W  number of 16-bit payload words; sampled at start.
- rd_req  output  1  one-cycle request for the next payload word.
- rd_data  input  16  payload word, MSB transmitted first.
- rd_valid  input  1  rd_data is valid this cycle; one pulse per request.
- handle  input  16  RN16 handle; used only with the optional feature.
- send_data  output  1  serial reply bit.
- fg_complete  output  1  frame finished, sticky.
- fg_busy  output  1  high from start through the dummy bit.
- err_underrun  output  1  sticky; a payload word was not available when needed.

Behaviour:
- Reset values: send_data=0, fg_complete=0, fg_busy=0, rd_req=0, err_underrun=0. FSM returns to IDLE and all counters and the CRC register clear. Reset asserted mid-frame aborts immediately with no partial-frame handling.
- Start detection: st_enc is registered, and its rising edge is detected in IDLE only. A rising edge in any other state is ignored.
- FSM states: IDLE, LEAD, HDR, PAY, HND, CRC, DUMMY, DONE.
- IDLE -> LEAD on start:
  - Latch trext, header_en, crc_en, word_cnt.
  - fg_busy goes high.
  - If word_cnt>0, pulse rd_req on the same cycle for word 0.
- LEAD:
  - Count the lead length, then go to HDR if header_en, else PAY if word_cnt>0, else HND (macro) / CRC if crc_en / DUMMY.
  - send_data=0 throughout LEAD.
- Underrun check: word 0 must arrive during LEAD. If it has not arrived at LEAD exit and the next state is PAY, set err_underrun and go to DUMMY.
- HDR: one cycle, send_data=0, and the bit enters the CRC.
- PAY (16 cycles per word):
  - Shift out the word MSB first.
  - On bit 0 of each word except the last, pulse rd_req for the next word.
  - The next word must be valid by bit 15. Otherwise set err_underrun, skip the remaining payload and CRC, and go to DUMMY.
  - A rd_valid with no outstanding request is ignored.
  - The prefetch holds one word of buffer.
- CRC:
  - Polynomial x^16+x^12+x^5+1, preset 0xFFFF, updated on every transmitted HDR/PAY/HND bit.
  - 16 cycles transmit the ones' complement of the register, MSB first.
  - The CRC is skipped if crc_en=0.
- DUMMY: one cycle, send_data=1.
- DONE:
  - fg_complete=1 (sticky), fg_busy=0, send_data=0.
  - Remains in DONE until reset; a new start is not accepted.
- Registered outputs: send_data is registered, and bit n is driven during cycle LEAD_x+n relative to the first LEAD cycle.
- Frame length in bits: header_en + 16*word_cnt + 16*crc_en (+16 with the macro) + 1.
- Degenerate frame: word_cnt=0 with crc_en=0 and header_en=0 sends only the dummy bit.

Optional Feature:
- Macro HANDLE_APPEND_EN.
- Defined: state HND follows PAY (or HDR/LEAD when word_cnt=0) and sends handle MSB first for 16 cycles, included in the CRC. Handle is sampled at start.
- Undefined: HND is absent, the handle port is ignored, and the frame length excludes the 16 handle bits.

Decomposition:
- Shared package frame_pkg:
  - FSM state encoding.
  - CRC16_POLY=16'h1021 and CRC16_PRESET=16'hFFFF.
  - LEAD_SHORT/LEAD_LONG defaults.
- One natural sub-module, crc16_ser: serial CRC register with init, enable, bit input and 16-bit state output. It is reusable by the command-decoder CRC check.

Test Plan:
- Minimal frame: word_cnt=1, rd_data=16'h0000, header_en=0, crc_en=1, trext=0 -> first bit at cycle 10; 16 zeros; CRC bits = ~CRC(0x0000 word) = 16'h1D0F ones'-complement per reference model; then dummy 1; fg_complete high from the following cycle.
- Lead length: trext=1, header_en=1 -> the header '0' appears at cycle 34; send_data=0 during cycles 0-33.
- Multi-word prefetch: word_cnt=3, rd_valid returned 5 cycles after each rd_req -> contiguous 48 payload bits; rd_req pulses at the start and at bit 0 of words 0 and 1 only; err_underrun=0.
- Underrun: word_cnt=2, second rd_valid withheld -> err_underrun=1 at bit 15 of word 0; dummy 1 follows; no CRC bits; fg_complete=1.
- Reset mid-frame: assert reset during PAY bit 7 -> all outputs 0 immediately. After release, a new st_enc rise produces a full correct frame.
- HANDLE_APPEND_EN build: word_cnt=0, handle=16'hA5A5, crc_en=1 -> bits A5A5, then CRC over A5A5, then dummy. A non-macro build sends the CRC of the empty payload (16'h0000 transmitted for preset FFFF).

Source files
------------

// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// frame_pkg : state encoding, CRC-16 constants and step function shared by
//             the reply frame generator and the command-decoder CRC check
// Rev 1.0
// ============================================================================
package frame_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_HDR   = 3'd2,
      S_PAY   = 3'd3,
      S_HND   = 3'd4,
      S_CRC   = 3'd5,
      S_DUMMY = 3'd6,
      S_DONE  = 3'd7
   } frm_state_t;

   localparam logic [15:0] CRC16_POLY   = 16'h1021;
   localparam logic [15:0] CRC16_PRESET = 16'hFFFF;

   localparam int LEAD_SHORT_DEF = 10;
   localparam int LEAD_LONG_DEF  = 34;

   // One MSB-first shift of x^16+x^12+x^5+1
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_ser.sv
`default_nettype none
// ============================================================================
// crc16_ser : bit-serial CRC-16 register (init / enable / bit in / state out)
// Rev 1.0
// ============================================================================
module crc16_ser
   import frame_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        init_i,
   input  logic        en_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         crc_q <= 16'h0000;
      end else if (init_i) begin
         crc_q <= CRC16_PRESET;
      end else if (en_i) begin
         crc_q <= crc16_step(crc_q, bit_i);
      end
   end

   assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/reply_frame_gen.sv
`default_nettype none
// ============================================================================
// reply_frame_gen : bit-serial tag reply framer (lead, header, payload,
//                   optional handle via HANDLE_APPEND_EN, CRC-16, dummy bit)
// Rev 1.0
// ============================================================================
module reply_frame_gen #(
   parameter int LEAD_SHORT = frame_pkg::LEAD_SHORT_DEF,
   parameter int LEAD_LONG  = frame_pkg::LEAD_LONG_DEF,
   parameter int WCNT_W     = 8
) (
   input  logic              clk_frm,
   input  logic              rst_for_new_package,
   input  logic              st_enc,
   input  logic              trext,
   input  logic              header_en,
   input  logic              crc_en,
   input  logic [WCNT_W-1:0] word_cnt,
   output logic              rd_req,
   input  logic [15:0]       rd_data,
   input  logic              rd_valid,
   input  logic [15:0]       handle,
   output logic              send_data,
   output logic              fg_complete,
   output logic              fg_busy,
   output logic              err_underrun
);
   import frame_pkg::*;

   // The FSM runs one cycle ahead of the registered send_data, so LEAD itself
   // lasts one cycle less than the visible lead window.
   localparam logic [5:0] LEAD_END_S = 6'(LEAD_SHORT - 2);
   localparam logic [5:0] LEAD_END_L = 6'(LEAD_LONG - 2);

   frm_state_t        state_q, state_d;
   logic              st_q, st_prev_q;
   logic [5:0]        lead_end_q, lead_end_d;
   logic              hdr_q, hdr_d, crc_en_q, crc_en_d;
   logic [WCNT_W-1:0] wrem_q, wrem_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [15:0]       sh_q, sh_d, buf_q, buf_d;
   logic              buf_vld_q, buf_vld_d, pend_q, pend_d;
   logic              send_q, send_d, busy_q, busy_d, cmp_q, cmp_d;
   logic              req_q, req_d, err_q, err_d;
   logic              w_start, w_acc, w_have, w_go_pay;
   logic [15:0]       w_word, w_crc;
   logic              w_crc_init, w_crc_en, w_crc_bit;
   frm_state_t        w_after_pay;
`ifdef HANDLE_APPEND_EN
   logic [15:0]       hnd_q, hnd_d;
`else
   logic              w_unused_handle;
   assign w_unused_handle = ^handle;
`endif

   assign w_start = st_q & ~st_prev_q;
   assign w_acc   = rd_valid & pend_q;
   assign w_have  = buf_vld_q | w_acc;
   assign w_word  = buf_vld_q ? buf_q : rd_data;

   always_comb begin
`ifdef HANDLE_APPEND_EN
      w_after_pay = S_HND;
`else
      w_after_pay = crc_en_q ? S_CRC : S_DUMMY;
`endif
   end

   always_comb begin
      state_d    = state_q;
      lead_end_d = lead_end_q;
      hdr_d      = hdr_q;
      crc_en_d   = crc_en_q;
      wrem_d     = wrem_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      buf_d      = buf_q;
      buf_vld_d  = buf_vld_q;
      pend_d     = pend_q;
      send_d     = 1'b0;
      busy_d     = busy_q;
      cmp_d      = cmp_q;
      req_d      = 1'b0;
      err_d      = err_q;
      w_go_pay   = 1'b0;
      w_crc_init = 1'b0;
      w_crc_en   = 1'b0;
      w_crc_bit  = 1'b0;
`ifdef HANDLE_APPEND_EN
      hnd_d      = hnd_q;
`endif
      // Single-word prefetch buffer; stray rd_valid without a request is dropped
      if (w_acc) begin
         buf_d     = rd_data;
         buf_vld_d = 1'b1;
         pend_d    = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (w_start) begin
               state_d    = S_LEAD;
               cnt_d      = 6'd0;
               lead_end_d = trext ? LEAD_END_L : LEAD_END_S;
               hdr_d      = header_en;
               crc_en_d   = crc_en;
               wrem_d     = word_cnt;
               busy_d     = 1'b1;
               buf_vld_d  = 1'b0;
               w_crc_init = 1'b1;
`ifdef HANDLE_APPEND_EN
               hnd_d      = handle;
`endif
               if (word_cnt != '0) begin
                  req_d  = 1'b1;
                  pend_d = 1'b1;
               end
            end
         end
         S_LEAD: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == lead_end_q) begin
               cnt_d = 6'd0;
               if (hdr_q)              state_d  = S_HDR;
               else if (wrem_q != '0)  w_go_pay = 1'b1;
               else                    state_d  = w_after_pay;
            end
         end
         S_HDR: begin
            w_crc_en = 1'b1;
            cnt_d    = 6'd0;
            if (wrem_q != '0) w_go_pay = 1'b1;
            else              state_d  = w_after_pay;
         end
         S_PAY: begin
            send_d    = sh_q[15];
            w_crc_en  = 1'b1;
            w_crc_bit = sh_q[15];
            sh_d      = {sh_q[14:0], 1'b0};
            cnt_d     = cnt_q + 6'd1;
            if (cnt_q[3:0] == 4'd0 && wrem_q != '0) begin
               req_d  = 1'b1;
               pend_d = 1'b1;
            end
            if (cnt_q[3:0] == 4'd15) begin
               cnt_d = 6'd0;
               if (wrem_q == '0) state_d  = w_after_pay;
               else              w_go_pay = 1'b1;
            end
         end
`ifdef HANDLE_APPEND_EN
         S_HND: begin
            send_d    = hnd_q[15];
            w_crc_en  = 1'b1;
            w_crc_bit = hnd_q[15];
            hnd_d     = {hnd_q[14:0], 1'b0};
            cnt_d     = cnt_q + 6'd1;
            if (cnt_q[3:0] == 4'd15) begin
               cnt_d   = 6'd0;
               state_d = crc_en_q ? S_CRC : S_DUMMY;
            end
         end
`endif
         S_CRC: begin
            send_d = ~w_crc[4'd15 - cnt_q[3:0]];
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q[3:0] == 4'd15) begin
               cnt_d   = 6'd0;
               state_d = S_DUMMY;
            end
         end
         S_DUMMY: begin
            send_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_d = 1'b0;
            cmp_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Next payload word must already be in hand; otherwise abandon payload and CRC
      if (w_go_pay) begin
         if (w_have) begin
            state_d   = S_PAY;
            sh_d      = w_word;
            buf_vld_d = 1'b0;
            wrem_d    = wrem_q - WCNT_W'(1);
         end else begin
            state_d = S_DUMMY;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_frm or posedge rst_for_new_package) begin
      if (rst_for_new_package) begin
         state_q    <= S_IDLE;
         st_q       <= 1'b0;
         st_prev_q  <= 1'b0;
         lead_end_q <= 6'd0;
         hdr_q      <= 1'b0;
         crc_en_q   <= 1'b0;
         wrem_q     <= '0;
         cnt_q      <= 6'd0;
         sh_q       <= 16'h0000;
         buf_q      <= 16'h0000;
         buf_vld_q  <= 1'b0;
         pend_q     <= 1'b0;
         send_q     <= 1'b0;
         busy_q     <= 1'b0;
         cmp_q      <= 1'b0;
         req_q      <= 1'b0;
         err_q      <= 1'b0;
`ifdef HANDLE_APPEND_EN
         hnd_q      <= 16'h0000;
`endif
      end else begin
         state_q    <= state_d;
         st_q       <= st_enc;
         st_prev_q  <= st_q;
         lead_end_q <= lead_end_d;
         hdr_q      <= hdr_d;
         crc_en_q   <= crc_en_d;
         wrem_q     <= wrem_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         buf_q      <= buf_d;
         buf_vld_q  <= buf_vld_d;
         pend_q     <= pend_d;
         send_q     <= send_d;
         busy_q     <= busy_d;
         cmp_q      <= cmp_d;
         req_q      <= req_d;
         err_q      <= err_d;
`ifdef HANDLE_APPEND_EN
         hnd_q      <= hnd_d;
`endif
      end
   end

   crc16_ser u_crc (
      .clk_i  (clk_frm),
      .rst_i  (rst_for_new_package),
      .init_i (w_crc_init),
      .en_i   (w_crc_en),
      .bit_i  (w_crc_bit),
      .crc_o  (w_crc)
   );

   assign send_data    = send_q;
   assign fg_busy      = busy_q;
   assign fg_complete  = cmp_q;
   assign rd_req       = req_q;
   assign err_underrun = err_q;

endmodule
`default_nettype wire
